// File: rtl/vga_image_viewer_pixel_cmd_if.sv
// Bus bundle for the pixel command port: Avalon-MM slave s1 plus the outbound pixel stream.
interface vga_image_viewer_pixel_cmd_if #(
    parameter int unsigned DATA_W = 32
) ();
    logic [1:0]        address;
    logic              chipselect;
    logic              read;
    logic              write;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    // Host side: drives s1 strobes and accepts the stream.
    modport master (
        output address, chipselect, read, write, writedata, out_ready,
        input  readdata, out_data, out_valid
    );

    // Block side.
    modport slave (
        input  address, chipselect, read, write, writedata, out_ready,
        output readdata, out_data, out_valid
    );
endinterface

// File: rtl/vga_image_viewer_pixel_cmd.sv
// CPU-to-VGA pixel command port: Avalon-MM writes fill a FIFO that drains over valid/ready.
// STATUS/CONTROL registers expose fill level, sticky overflow, enable and flush.
module vga_image_viewer_pixel_cmd #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 32
) (
    input logic                          clk,
    input logic                          reset_n,
    vga_image_viewer_pixel_cmd_if.slave  bus
);
    localparam logic [ADDR_W:0] FullCount = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic              enable;
    logic              overflow;

    logic              wr;
    logic              rd;
    logic              wr_data;
    logic              wr_ctrl;
    logic              flush;
    logic              full;
    logic              empty;
    logic              pop;
    logic              push;
    logic [DATA_W-1:0] head;
    logic [31:0]       head_ext;
    logic [31:0]       status;
    logic [31:0]       rd_mux;

    // Strobe decode, FIFO handshake and readback mux, all from registered state.
    always_comb begin
        wr       = bus.chipselect & bus.write;
        rd       = bus.chipselect & bus.read;
        wr_data  = wr & (bus.address == 2'd0);
        wr_ctrl  = wr & (bus.address == 2'd2);
        flush    = wr_ctrl & bus.writedata[2];
        full     = (count == FullCount);
        empty    = (count == '0);
        pop      = enable & ~empty & bus.out_ready;
        // A full FIFO still accepts a word when the head leaves in the same cycle.
        push     = wr_data & (~full | pop);
        head     = mem[rd_ptr];

        head_ext = '0;
        head_ext[DATA_W-1:0] = head;

        status             = '0;
        status[ADDR_W:0]   = count;
        status[16]         = empty;
        status[17]         = full;
        status[18]         = overflow;
        status[24]         = enable;

        rd_mux = '0;
        case (bus.address)
            2'd0:    rd_mux = empty ? 32'h0 : head_ext;
            2'd1:    rd_mux = status;
            2'd2:    rd_mux = {31'h0, enable};
            default: rd_mux = '0;
        endcase
    end

    // Stream outputs; data is forced to zero while nothing is offered.
    always_comb begin
        bus.out_valid = enable & ~empty;
        bus.out_data  = (enable & ~empty) ? head : '0;
    end

    // FIFO storage; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (reset_n && push) begin
            mem[wr_ptr] <= bus.writedata[DATA_W-1:0];
        end
    end

    // Pointers, fill count, control bits and registered read data.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            enable       <= 1'b0;
            overflow     <= 1'b0;
            bus.readdata <= '0;
        end else begin
            if (flush) begin
                // Flush wins over any pop offered this cycle.
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                if (push && !pop) begin
                    count <= count + 1'b1;
                end else if (pop && !push) begin
                    count <= count - 1'b1;
                end
            end

            if (wr_ctrl) begin
                enable <= bus.writedata[0];
                if (bus.writedata[1]) begin
                    overflow <= 1'b0;
                end
            end
            if (wr_data && !push) begin
                overflow <= 1'b1;
            end

            bus.readdata <= rd ? rd_mux : 32'h0;
        end
    end
endmodule

// File: tb/tb_vga_image_viewer_pixel_cmd.sv
// Self-checking bench: directed vector table, hand sequences and random traffic against a queue model.
module tb_vga_image_viewer_pixel_cmd;
    logic clk = 1'b0;
    logic reset_n = 1'b0;

    vga_image_viewer_pixel_cmd_if #(.DATA_W(32)) bus ();

    vga_image_viewer_pixel_cmd #(
        .DEPTH  (16),
        .ADDR_W (4),
        .DATA_W (32)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    // Reference model: FIFO as a queue plus the two control flags.
    logic [31:0] mq[$];
    bit          m_en  = 1'b0;
    bit          m_ovf = 1'b0;

    typedef struct {
        logic        cs;
        logic        rd;
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] wd;
        logic        rdy;
        logic [31:0] exp_rdata;
        logic        exp_valid;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vt[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s       = '0;
        s[4:0]  = 5'(mq.size());
        s[16]   = (mq.size() == 0);
        s[17]   = (mq.size() == 16);
        s[18]   = m_ovf;
        s[24]   = m_en;
        return s;
    endfunction

    task automatic set_idle();
        bus.chipselect = 1'b0;
        bus.read       = 1'b0;
        bus.write      = 1'b0;
        bus.address    = 2'd0;
        bus.writedata  = 32'h0;
    endtask

    // One clock with the current inputs; model advances and all outputs are compared.
    task automatic tick();
        logic [31:0] exp_rd;
        logic [31:0] wd;
        logic [1:0]  a;
        bit          pop;
        bit          w;
        bit          rst;
        rst = !reset_n;
        a   = bus.address;
        wd  = bus.writedata;
        w   = bus.chipselect && bus.write;
        exp_rd = 32'h0;
        if (!rst && bus.chipselect && bus.read) begin
            case (a)
                2'd0:    exp_rd = (mq.size() != 0) ? mq[0] : 32'h0;
                2'd1:    exp_rd = m_status();
                2'd2:    exp_rd = {31'h0, m_en};
                default: exp_rd = 32'h0;
            endcase
        end
        pop = m_en && (mq.size() != 0) && bus.out_ready;
        @(posedge clk);
        #1;
        if (rst) begin
            mq.delete();
            m_en  = 1'b0;
            m_ovf = 1'b0;
        end else if (w && a == 2'd2) begin
            if (wd[2]) mq.delete();
            else if (pop) void'(mq.pop_front());
            m_en = wd[0];
            if (wd[1]) m_ovf = 1'b0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (w && a == 2'd0) begin
                if (mq.size() < 16) mq.push_back(wd);
                else m_ovf = 1'b1;
            end
        end
        check("readdata", bus.readdata, exp_rd);
        check("out_valid", {31'h0, bus.out_valid}, {31'h0, (m_en && mq.size() != 0)});
        if (m_en && mq.size() != 0) check("out_data", bus.out_data, mq[0]);
    endtask

    task automatic wr_tick(input logic [1:0] a, input logic [31:0] d);
        bus.chipselect = 1'b1;
        bus.write      = 1'b1;
        bus.read       = 1'b0;
        bus.address    = a;
        bus.writedata  = d;
        tick();
        set_idle();
    endtask

    task automatic rd_tick(input logic [1:0] a, output logic [31:0] d);
        bus.chipselect = 1'b1;
        bus.read       = 1'b1;
        bus.write      = 1'b0;
        bus.address    = a;
        tick();
        d = bus.readdata;
        set_idle();
    endtask

    initial begin
        logic [31:0] r;

        // Directed vectors: post-reset status, enable-gated drain, register readback.
        vt[0]  = '{1'b1, 1'b1, 1'b0, 2'd1, 32'h0,  1'b0, 32'h0001_0000, 1'b0, 32'h0};
        vt[1]  = '{1'b1, 1'b0, 1'b1, 2'd0, 32'hA1, 1'b0, 32'h0,         1'b0, 32'h0};
        vt[2]  = '{1'b1, 1'b0, 1'b1, 2'd0, 32'hA2, 1'b0, 32'h0,         1'b0, 32'h0};
        vt[3]  = '{1'b1, 1'b0, 1'b1, 2'd0, 32'hA3, 1'b0, 32'h0,         1'b0, 32'h0};
        vt[4]  = '{1'b1, 1'b1, 1'b0, 2'd1, 32'h0,  1'b0, 32'h0000_0003, 1'b0, 32'h0};
        vt[5]  = '{1'b1, 1'b1, 1'b0, 2'd0, 32'h0,  1'b0, 32'h0000_00A1, 1'b0, 32'h0};
        vt[6]  = '{1'b1, 1'b0, 1'b1, 2'd2, 32'h1,  1'b1, 32'h0,         1'b1, 32'hA1};
        vt[7]  = '{1'b0, 1'b0, 1'b0, 2'd0, 32'h0,  1'b1, 32'h0,         1'b1, 32'hA2};
        vt[8]  = '{1'b0, 1'b0, 1'b0, 2'd0, 32'h0,  1'b1, 32'h0,         1'b1, 32'hA3};
        vt[9]  = '{1'b0, 1'b0, 1'b0, 2'd0, 32'h0,  1'b1, 32'h0,         1'b0, 32'h0};
        vt[10] = '{1'b1, 1'b1, 1'b0, 2'd1, 32'h0,  1'b1, 32'h0101_0000, 1'b0, 32'h0};
        vt[11] = '{1'b1, 1'b1, 1'b0, 2'd2, 32'h0,  1'b1, 32'h0000_0001, 1'b0, 32'h0};
        vt[12] = '{1'b1, 1'b1, 1'b0, 2'd3, 32'h0,  1'b1, 32'h0,         1'b0, 32'h0};
        vt[13] = '{1'b1, 1'b0, 1'b1, 2'd2, 32'h0,  1'b1, 32'h0,         1'b0, 32'h0};

        set_idle();
        bus.out_ready = 1'b0;
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        check("reset readdata", bus.readdata, 32'h0);
        check("reset out_valid", {31'h0, bus.out_valid}, 32'h0);

        for (int i = 0; i < 14; i++) begin
            bus.chipselect = vt[i].cs;
            bus.read       = vt[i].rd;
            bus.write      = vt[i].wr;
            bus.address    = vt[i].addr;
            bus.writedata  = vt[i].wd;
            bus.out_ready  = vt[i].rdy;
            tick();
            check($sformatf("vec%0d readdata", i), bus.readdata, vt[i].exp_rdata);
            check($sformatf("vec%0d out_valid", i), {31'h0, bus.out_valid},
                  {31'h0, vt[i].exp_valid});
            if (vt[i].exp_valid) check($sformatf("vec%0d out_data", i), bus.out_data, vt[i].exp_data);
        end
        set_idle();
        bus.out_ready = 1'b0;

        // Overflow: 17 words into a 16-deep FIFO while disabled.
        for (int i = 0; i < 17; i++) wr_tick(2'd0, 32'(i));
        rd_tick(2'd1, r);
        check("full status", r, 32'h0006_0010);
        wr_tick(2'd2, 32'h3);
        check("enable after ctl3", {31'h0, bus.out_valid}, 32'h1);

        // Full FIFO accepts a write when the head pops in the same cycle.
        bus.out_ready = 1'b1;
        wr_tick(2'd0, 32'h55);
        bus.out_ready = 1'b0;
        rd_tick(2'd1, r);
        check("full push+pop status", r, 32'h0102_0010);
        bus.out_ready = 1'b1;
        for (int j = 0; j < 16; j++) begin
            check($sformatf("drain%0d", j), bus.out_data, (j == 15) ? 32'h55 : 32'(j + 1));
            tick();
        end
        check("drained", {31'h0, bus.out_valid}, 32'h0);

        // Flush with pop offered in the same cycle.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) wr_tick(2'd0, 32'hC0 + 32'(i));
        bus.out_ready = 1'b1;
        wr_tick(2'd2, 32'h5);
        check("flush out_valid", {31'h0, bus.out_valid}, 32'h0);
        bus.out_ready = 1'b0;
        rd_tick(2'd1, r);
        check("flush status", r, 32'h0101_0000);

        // Streaming push/pop of 40 words wraps the pointers several times.
        bus.out_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            wr_tick(2'd0, 32'h100 + 32'(k));
            check($sformatf("wrap%0d", k), bus.out_data, 32'h100 + 32'(k));
        end
        tick();
        check("wrap empty", {31'h0, bus.out_valid}, 32'h0);

        // Reset mid-operation with a read strobed on the reset cycle.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 7; i++) wr_tick(2'd0, 32'hE0 + 32'(i));
        reset_n        = 1'b0;
        bus.chipselect = 1'b1;
        bus.read       = 1'b1;
        bus.address    = 2'd1;
        tick();
        set_idle();
        reset_n = 1'b1;
        check("rst readdata", bus.readdata, 32'h0);
        check("rst out_valid", {31'h0, bus.out_valid}, 32'h0);
        rd_tick(2'd1, r);
        check("rst status", r, 32'h0001_0000);

        // Random traffic against the model.
        for (int c = 0; c < 400; c++) begin
            logic [31:0] wd;
            reset_n        = ($urandom_range(0, 149) != 0);
            bus.chipselect = ($urandom_range(0, 3) != 0);
            bus.read       = $urandom_range(0, 1);
            bus.write      = ($urandom_range(0, 2) != 0);
            bus.address    = ($urandom_range(0, 2) != 0) ? 2'd0 : 2'($urandom_range(1, 3));
            wd             = $urandom;
            if ($urandom_range(0, 9) != 0) wd[2] = 1'b0;
            if ($urandom_range(0, 3) != 0) wd[0] = 1'b1;
            bus.writedata  = wd;
            bus.out_ready  = ($urandom_range(0, 2) == 0);
            tick();
        end
        reset_n = 1'b1;
        set_idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
